kernel_b_in_fifo: RTL

KERNEL_B_IN_FIFO -- requirements
Module: kernel_b_in_fifo

---
 rtl/kernel_b_pkg.sv | 19 +
 rtl/kernel_b_fifo_mem.sv | 28 ++
 rtl/kernel_b_in_fifo.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/kernel_b_pkg.sv
// Shared defaults and state encoding for the kernel_B input FIFO.
package kernel_b_pkg;

    localparam int STREAMW_DEF = 32;
    localparam int DEPTH_DEF   = 4;
    localparam int NELEM_DEF   = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Saturating 32-bit increment used by the optional stall statistic.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

endpackage

// File: rtl/kernel_b_fifo_mem.sv
// FIFO storage: DEPTH x WIDTH, synchronous write, asynchronous read.
// Contents are not reset; the control logic never exposes an unwritten slot.
module kernel_b_fifo_mem
    import kernel_b_pkg::*;
#(
    parameter int WIDTH = STREAMW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write port: capture the pushed word at the write pointer.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/kernel_b_in_fifo.sv
// Input FIFO in front of kernelTop_kernel_B: first-word-fall-through buffer
// with a delivery counter that closes the stream after NELEM words.
// Optional build macro KERNEL_B_IN_FIFO_STATS_EN adds a saturating
// stall_cnt output (cycles with ovalid=1 and oready=0).
module kernel_b_in_fifo
    import kernel_b_pkg::*;
#(
    parameter int STREAMW = STREAMW_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int NELEM   = NELEM_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ivalid,
    output logic                     iready,
    input  logic [STREAMW-1:0]       in_s0,
    output logic                     ovalid,
    input  logic                     oready,
    output logic [STREAMW-1:0]       out_s0,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     done
`ifdef KERNEL_B_IN_FIFO_STATS_EN
    ,
    output logic [31:0]              stall_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(NELEM + 1);

    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LEVEL_ZERO = {LW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(NELEM - 1);
    localparam logic [CW-1:0] CNT_END    = CW'(NELEM);

    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [LW-1:0]      level_r;
    logic [CW-1:0]      cnt_r;
    state_t             state_r;
    state_t             state_s;
    // Held low through reset so iready stays 0 until the first edge after release.
    logic               en_r;
    logic               iready_s;
    logic               ovalid_s;
    logic               push_s;
    logic               pop_s;
    logic [STREAMW-1:0] rd_data_s;

    // Handshake qualifiers, derived only from registered state.
    always_comb begin
        iready_s = en_r & (level_r < LEVEL_FULL) & (state_r != DONE);
        ovalid_s = (level_r != LEVEL_ZERO);
        push_s   = ivalid & iready_s;
        pop_s    = ovalid_s & oready;
    end

    // Next-state logic for the stream lifecycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (push_s) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (pop_s && (cnt_r == CNT_LAST)) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                state_s = DONE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register and post-reset input enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            en_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            en_r    <= 1'b1;
        end
    end

    // Pointers and occupancy; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= LEVEL_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LEVEL_ONE;
                2'b01:   level_r <= level_r - LEVEL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // Delivery counter: one step per word handed downstream, capped at NELEM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (pop_s && (cnt_r != CNT_END)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

`ifdef KERNEL_B_IN_FIFO_STATS_EN
    logic [31:0] stall_cnt_r;

    // Count cycles where a word is offered but downstream holds off.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_r <= 32'd0;
        end else if (ovalid_s && !oready) begin
            stall_cnt_r <= sat_inc32(stall_cnt_r);
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

    kernel_b_fifo_mem #(
        .WIDTH (STREAMW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push_s),
        .waddr (wr_ptr_r),
        .wdata (in_s0),
        .raddr (rd_ptr_r),
        .rdata (rd_data_s)
    );

    assign iready = iready_s;
    assign ovalid = ovalid_s;
    assign out_s0 = rd_data_s;
    assign level  = level_r;
    assign done   = (state_r == DONE);

endmodule
